// File: rtl/button_array.sv
// rtl/button_array.sv - multi-channel button front end with debounce, edges and hold/repeat events
//
// Purpose: for each of CHANNELS raw push-button inputs, synchronise to i_clk,
// optionally invert (ACTIVE_LOW), debounce with a per-channel counter, derive
// press/release edge pulses and run a press/hold FSM that emits one long-press
// pulse followed by periodic auto-repeat pulses while the button stays held.
// Channels share nothing but the clock and reset.
//
// Ports:
//   i_clk          single clock for all logic
//   i_reset        synchronous, active-high reset
//   i_noisy        raw asynchronous button inputs, one bit per channel
//   o_debounced    stable pressed level per channel (active-high pressed)
//   o_p_edge       1-cycle pulse when o_debounced rises
//   o_n_edge       1-cycle pulse when o_debounced falls
//   o_edge         o_p_edge | o_n_edge
//   o_long_press   1-cycle pulse HOLD_CYCLES after the press edge
//   o_repeat       1-cycle pulse every REPEAT_CYCLES after o_long_press

module button_array #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_noisy,
  output logic [CHANNELS-1:0] o_debounced,
  output logic [CHANNELS-1:0] o_p_edge,
  output logic [CHANNELS-1:0] o_n_edge,
  output logic [CHANNELS-1:0] o_edge,
  output logic [CHANNELS-1:0] o_long_press,
  output logic [CHANNELS-1:0] o_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [HW-1:0] HOLD_T   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_T    = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] HCNT_ONE = HW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_REPEAT
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    logic [1:0]    r_sync;
    logic          w_s;
    logic [DW-1:0] r_cnt;
    logic          r_deb;
    logic          r_deb_q;
    logic          w_deb_next;
    state_t        r_state;
    state_t        w_state_next;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_next;
    logic          r_long;
    logic          r_rep;
    logic          w_long_next;
    logic          w_rep_next;

    assign w_s = r_sync[1] ^ ACTIVE_LOW;

    // Level the debouncer will hold after this edge. The FSM keys off this
    // rather than the registered level so that it enters PRESS on the same
    // edge debounced rises, and so a release landing on a terminal count
    // suppresses the pulse instead of coinciding with n_edge.
    always_comb begin
      w_deb_next = r_deb;
      if ((w_s != r_deb) && (r_cnt == DEB_LAST)) begin
        w_deb_next = w_s;
      end
    end

    // Synchroniser flops reset to the raw idle level so w_s starts at 0.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_sync  <= {2{ACTIVE_LOW}};
        r_cnt   <= '0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], i_noisy[g]};
        r_deb   <= w_deb_next;
        r_deb_q <= r_deb;
        if ((w_s == r_deb) || (r_cnt == DEB_LAST)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DEB_ONE;
        end
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_hcnt_next  = r_hcnt;
      w_long_next  = 1'b0;
      w_rep_next   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_deb_next && !r_deb) begin
            w_state_next = ST_PRESS;
            w_hcnt_next  = HCNT_ONE;
          end
        end
        ST_PRESS: begin
          if (!w_deb_next) begin
            w_state_next = ST_IDLE;
            w_hcnt_next  = '0;
          end else if (r_hcnt == HOLD_T) begin
            w_long_next  = 1'b1;
            w_state_next = ST_REPEAT;
            w_hcnt_next  = HCNT_ONE;
          end else begin
            w_hcnt_next = r_hcnt + HCNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!w_deb_next) begin
            w_state_next = ST_IDLE;
            w_hcnt_next  = '0;
          end else if (r_hcnt == REP_T) begin
            w_rep_next  = 1'b1;
            w_hcnt_next = HCNT_ONE;
          end else begin
            w_hcnt_next = r_hcnt + HCNT_ONE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_hcnt_next  = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_state <= ST_IDLE;
        r_hcnt  <= '0;
        r_long  <= 1'b0;
        r_rep   <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_hcnt  <= w_hcnt_next;
        r_long  <= w_long_next;
        r_rep   <= w_rep_next;
      end
    end

    assign o_debounced[g]  = r_deb;
    assign o_p_edge[g]     = r_deb & ~r_deb_q;
    assign o_n_edge[g]     = ~r_deb & r_deb_q;
    assign o_edge[g]       = r_deb ^ r_deb_q;
    assign o_long_press[g] = r_long;
    assign o_repeat[g]     = r_rep;
  end

endmodule

// File: tb/tb_button_array.sv
// tb/tb_button_array.sv - self-checking bench for button_array
module tb_button_array;

  localparam int D = 8;
  localparam int H = 20;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       rst_al;
  logic [3:0] noisy;
  logic [3:0] noisy_al;

  logic [3:0] a_deb [2];
  logic [3:0] a_p   [2];
  logic [3:0] a_n   [2];
  logic [3:0] a_e   [2];
  logic [3:0] a_l   [2];
  logic [3:0] a_r   [2];

  always #5 clk = ~clk;

  button_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_noisy(noisy),
    .o_debounced(a_deb[0]), .o_p_edge(a_p[0]), .o_n_edge(a_n[0]), .o_edge(a_e[0]),
    .o_long_press(a_l[0]), .o_repeat(a_r[0])
  );

  button_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .i_clk(clk), .i_reset(rst_al), .i_noisy(noisy_al),
    .o_debounced(a_deb[1]), .o_p_edge(a_p[1]), .o_n_edge(a_n[1]), .o_edge(a_e[1]),
    .o_long_press(a_l[1]), .o_repeat(a_r[1])
  );

  // kind: 0 p_edge, 1 n_edge, 2 long_press, 3 repeat
  typedef struct {
    int d;
    int kind;
    int cyc;
    int ch;
  } ev_t;

  // rel[ch]: raw release edge offset from the press edge r
  typedef struct {
    logic [3:0] mask;
    int         rel [4];
  } row_t;

  ev_t        sbq[$];
  row_t       tbl [6];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  bit         mon_en = 1'b0;
  logic [1:0] rst_q = 2'b11;
  logic [3:0] exp_deb [2];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= {rst_al, reset};
  end

  function automatic void push(input int d, input int kind, input int c, input int ch);
    ev_t e;
    e.d = d;
    e.kind = kind;
    e.cyc = c;
    e.ch = ch;
    sbq.push_back(e);
  endfunction

  task automatic chk(input string nm, input int d, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin : mon_blk
      logic [3:0] ep [2];
      logic [3:0] en [2];
      logic [3:0] el [2];
      logic [3:0] er [2];
      for (int d = 0; d < 2; d++) begin
        ep[d] = '0;
        en[d] = '0;
        el[d] = '0;
        er[d] = '0;
      end
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          case (sbq[i].kind)
            0: ep[sbq[i].d][sbq[i].ch] = 1'b1;
            1: en[sbq[i].d][sbq[i].ch] = 1'b1;
            2: el[sbq[i].d][sbq[i].ch] = 1'b1;
            default: er[sbq[i].d][sbq[i].ch] = 1'b1;
          endcase
          sbq.delete(i);
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (rst_q[d]) exp_deb[d] = '0;
        exp_deb[d] = (exp_deb[d] | ep[d]) & ~en[d];
        chk("debounced", d, a_deb[d], exp_deb[d]);
        chk("p_edge", d, a_p[d], ep[d]);
        chk("n_edge", d, a_n[d], en[d]);
        chk("edge", d, a_e[d], ep[d] | en[d]);
        chk("long_press", d, a_l[d], el[d]);
        chk("repeat", d, a_r[d], er[d]);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    rst_al     = 1'b1;
    noisy      = 4'h0;
    noisy_al   = 4'hF;
    exp_deb[0] = '0;
    exp_deb[1] = '0;

    tbl[0].mask = 4'b0001; tbl[0].rel = '{38, 0, 0, 0};   // clean press, 3 repeats
    tbl[1].mask = 4'b0100; tbl[1].rel = '{0, 0, 19, 0};   // release just before hold
    tbl[2].mask = 4'b0100; tbl[2].rel = '{0, 0, 20, 0};   // release on hold terminal
    tbl[3].mask = 4'b1001; tbl[3].rel = '{32, 0, 0, 22};  // simultaneous, ch3 early release
    tbl[4].mask = 4'b0010; tbl[4].rel = '{0, 25, 0, 0};   // release on repeat terminal
    tbl[5].mask = 4'b1111; tbl[5].rel = '{21, 26, 20, 45};

    step();
    mon_en = 1'b1;
    step();
    step();
    reset  = 1'b0;
    rst_al = 1'b0;
    repeat (4) step();

    for (int k = 0; k < 6; k++) begin
      int r;
      int last;
      r    = cyc + 1;
      last = 0;
      for (int ch = 0; ch < 4; ch++) begin
        if (tbl[k].mask[ch]) begin
          int t;
          t = r + D + 1;
          push(0, 0, t, ch);
          push(0, 1, r + tbl[k].rel[ch] + D + 1, ch);
          if (H < tbl[k].rel[ch]) push(0, 2, t + H, ch);
          for (int m = 1; H + m * R < tbl[k].rel[ch]; m++) push(0, 3, t + H + m * R, ch);
          if (tbl[k].rel[ch] > last) last = tbl[k].rel[ch];
        end
      end
      noisy = tbl[k].mask;
      while (cyc < r + last + D + 4) begin
        step();
        for (int ch = 0; ch < 4; ch++) begin
          if (tbl[k].mask[ch] && (cyc == r + tbl[k].rel[ch] - 1)) noisy[ch] = 1'b0;
        end
      end
    end

    // Bounce: 7 high / 3 low never reaches the 8-cycle threshold.
    for (int i = 0; i < 100; i++) begin
      noisy[1] = ((i % 10) < 7);
      step();
    end
    noisy[1] = 1'b0;
    repeat (12) step();

    // Active-low channel 0: press, reset mid-hold, re-detect, release.
    begin
      int t2;
      t2 = cyc + 1 + D + 1;
      noisy_al[0] = 1'b0;
      push(1, 0, t2, 0);
      while (cyc < t2 + 9) step();
      rst_al = 1'b1;
      step();
      step();
      rst_al = 1'b0;
      t2 = cyc + 1 + D + 1;
      push(1, 0, t2, 0);
      while (cyc < t2 + 2) step();
      noisy_al[0] = 1'b1;
      push(1, 1, cyc + 1 + D + 1, 0);
      repeat (14) step();
    end

    repeat (5) step();
    n_total++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL pending_events got=%0d want=0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
